// File: rtl/game_pkg.sv
// Shared types for the dice-game turn sequencer: state/result encodings and
// the bit positions of the one-hot phase-enable vector.
package game_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_ROLL   = 3'd1,
    S_CHOOSE = 3'd2,
    S_WON    = 3'd3,
    S_LOST   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_CONTINUE = 2'b00,
    RES_WIN      = 2'b01,
    RES_LOSE     = 2'b10,
    RES_RSVD     = 2'b11
  } result_e;

  localparam int PH_START  = 0;
  localparam int PH_ROLL   = 1;
  localparam int PH_CHOOSE = 2;
  localparam int PH_END    = 3;

endpackage

// File: rtl/phase_decode.sv
// Maps a sequencer state to the one-hot enable of the phase module that owns it.
// Illegal encodings decode to the start phase, matching the FSM's recovery target.
module phase_decode
  import game_pkg::*;
(
  input  state_e      state,
  output logic [3:0]  phase_en
);

  always_comb begin
    phase_en = '0;
    case (state)
      S_START:       phase_en[PH_START]  = 1'b1;
      S_ROLL:        phase_en[PH_ROLL]   = 1'b1;
      S_CHOOSE:      phase_en[PH_CHOOSE] = 1'b1;
      S_WON, S_LOST: phase_en[PH_END]    = 1'b1;
      default:       phase_en[PH_START]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer for the dice game: hands the turn between phase modules via a
// registered one-hot enable and entry pulse, counts continues and latches the outcome.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int MAX_TURNS = 10,
  parameter int TURN_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_done,
  input  logic              roll_done,
  input  logic              choose_done,
  input  logic [1:0]        choose_result,
  input  logic              end_done,
  output logic [3:0]        phase_en,
  output logic              phase_go,
  output logic [TURN_W-1:0] turns,
  output logic [2:0]        state,
  output logic              won,
  output logic              lost,
  output logic              err
);

  // state    | meaning
  // S_START  | start phase owns the turn; counter and outcome cleared on entry
  // S_ROLL   | roll phase owns the turn
  // S_CHOOSE | choose phase decides continue / win / lose
  // S_WON    | end display, player won
  // S_LOST   | end display, player lost (explicit or turns exhausted)

  state_e            state_q;
  state_e            state_nxt;
  logic [3:0]        phase_en_nxt;
  logic              fresh;
  logic              legal;
  logic              take;
  logic              stray;
  result_e           res;
  logic [TURN_W-1:0] turns_inc;

  assign state     = state_q;
  assign res       = result_e'(choose_result);
  assign turns_inc = turns + 1'b1;

  always_comb begin
    state_nxt = state_q;
    take      = 1'b0;
    stray     = 1'b0;
    legal     = 1'b1;
    case (state_q)
      S_START: begin
        stray = roll_done | choose_done | end_done;
        if (start_done) begin
          take      = 1'b1;
          state_nxt = S_ROLL;
        end
      end
      S_ROLL: begin
        stray = start_done | choose_done | end_done;
        if (roll_done) begin
          take      = 1'b1;
          state_nxt = S_CHOOSE;
        end
      end
      S_CHOOSE: begin
        stray = start_done | roll_done | end_done;
        if (choose_done) begin
          take = 1'b1;
          case (res)
            RES_WIN:  state_nxt = S_WON;
            RES_LOSE: state_nxt = S_LOST;
            default:  state_nxt = (turns_inc == TURN_W'(MAX_TURNS)) ? S_LOST : S_ROLL;
          endcase
        end
      end
      S_WON, S_LOST: begin
        stray = start_done | roll_done | choose_done;
        if (end_done) begin
          take      = 1'b1;
          state_nxt = S_START;
        end
      end
      default: begin
        legal     = 1'b0;
        state_nxt = S_START;
      end
    endcase
    // A done still high in the entry cycle belongs to the previous occupancy.
    if ((phase_go || fresh) && legal) begin
      take      = 1'b0;
      state_nxt = state_q;
    end
  end

  phase_decode u_phase_decode (
    .state    (state_nxt),
    .phase_en (phase_en_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_START;
      phase_en <= 4'b0001;
      phase_go <= 1'b0;
      turns    <= '0;
      won      <= 1'b0;
      lost     <= 1'b0;
      err      <= 1'b0;
      fresh    <= 1'b1;
    end else begin
      fresh    <= 1'b0;
      phase_go <= take | fresh | ~legal;
      state_q  <= state_nxt;
      phase_en <= phase_en_nxt;
      if (stray || !legal || (take && state_q == S_CHOOSE && res == RES_RSVD))
        err <= 1'b1;
      if (take) begin
        case (state_nxt)
          S_START: begin
            turns <= '0;
            won   <= 1'b0;
            lost  <= 1'b0;
          end
          S_WON:   won  <= 1'b1;
          S_LOST:  lost <= 1'b1;
          default: ;
        endcase
        if (state_q == S_CHOOSE && res != RES_WIN && res != RES_LOSE)
          turns <= turns_inc;
      end
      if (!legal) begin
        turns <= '0;
        won   <= 1'b0;
        lost  <= 1'b0;
      end
    end
  end

endmodule
